// File: rtl/filter_channel_scheduler.sv
// Round-robin scheduler sharing one 3-tap filter datapath among NCH channels.
// Tracks per-channel warm-up fill, drives tap loads, and realigns results to the datapath latency.
module filter_channel_scheduler #(
    parameter int NCH = 4,
    parameter int CW  = 2,
    parameter int DW  = 16,
    parameter int LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    in_valid,
    input  logic [NCH*DW-1:0] in_data,
    output logic [NCH-1:0]    in_ready,
    input  logic [NCH-1:0]    flush,
    input  logic              dp_stall,
    output logic              dp_en,
    output logic [CW-1:0]     dp_ch,
    output logic [DW-1:0]     dp_data,
    output logic              load0,
    output logic              load1,
    output logic              load2,
    output logic              out_valid,
    output logic [CW-1:0]     out_ch,
    output logic              busy
);

    logic [CW-1:0]          ptr_q;
    logic [NCH-1:0][1:0]    fill_q;
    logic [CW-1:0]          gnt;
    logic                   gnt_vld;
    logic                   xfer;
    logic [1:0]             f;
    logic [1:0]             fill_d;
    int                     idx;

    // Stage 0 is the issue register itself; stage LAT lines up with the datapath result.
    logic [LAT:0]           vld_pipe_q;
    logic [LAT:0]           pri_pipe_q;
    logic [LAT:0][CW-1:0]   ch_pipe_q;
    logic [DW-1:0]          data_q;
    logic                   load0_q, load1_q, load2_q;

    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!gnt_vld && in_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt     = CW'(idx);
            end
        end
    end

    assign xfer = gnt_vld & ~dp_stall;

    always_comb begin
        in_ready = '0;
        if (xfer) in_ready[gnt] = 1'b1;
    end

    // A same-cycle flush wins over the stored history of the granted channel.
    assign f      = flush[gnt] ? 2'd0 : fill_q[gnt];
    assign fill_d = (f == 2'd2) ? 2'd2 : f + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            fill_q     <= '0;
            vld_pipe_q <= '0;
            pri_pipe_q <= '0;
            ch_pipe_q  <= '0;
            data_q     <= '0;
            load0_q    <= 1'b0;
            load1_q    <= 1'b0;
            load2_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (xfer && (gnt == CW'(i))) fill_q[i] <= fill_d;
                else if (flush[i])           fill_q[i] <= 2'd0;
            end
            if (xfer) begin
                ptr_q        <= (gnt == CW'(NCH-1)) ? '0 : gnt + 1'b1;
                ch_pipe_q[0] <= gnt;
                data_q       <= in_data[gnt*DW +: DW];
            end
            vld_pipe_q[0] <= xfer;
            pri_pipe_q[0] <= xfer && (f == 2'd2);
            load0_q       <= xfer;
            load1_q       <= xfer && (f >= 2'd1);
            load2_q       <= xfer && (f == 2'd2);
            for (int s = 1; s <= LAT; s++) begin
                vld_pipe_q[s] <= vld_pipe_q[s-1];
                pri_pipe_q[s] <= pri_pipe_q[s-1];
                ch_pipe_q[s]  <= ch_pipe_q[s-1];
            end
        end
    end

    assign dp_en     = vld_pipe_q[0];
    assign dp_ch     = ch_pipe_q[0];
    assign dp_data   = data_q;
    assign load0     = load0_q;
    assign load1     = load1_q;
    assign load2     = load2_q;
    assign out_valid = pri_pipe_q[LAT];
    assign out_ch    = ch_pipe_q[LAT];
    assign busy      = |vld_pipe_q;

endmodule
